// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   Receives PS/2 device-to-host frames (start, 8 data bits LSB first, odd parity,
//   stop) from a keyboard and presents each good scan-code byte on o_count with a
//   single-cycle o_ready pulse. Frames with a bad start bit, a bad stop bit, a
//   mid-frame clock timeout or (optionally) a parity error are dropped and flagged
//   with a single-cycle o_error pulse. Everything runs in the i_clk domain; the
//   PS/2 clock is oversampled, synchronized and glitch-filtered. Receive only: the
//   PS/2 pins are never driven.
//
//   Parameters
//     FILTER_LEN      consecutive equal synced samples needed to move filtered ps2_clk
//     TIMEOUT_CYCLES  max i_clk cycles between ps2_clk falls inside a frame
//
//   Configuration macro
//     PS2_RX_PARITY_CHECK_EN  defined: frames with wrong odd parity are discarded.
//                             undefined: the parity bit is sampled and ignored.
//
//   Ports
//     i_clk       system clock
//     i_rst_n     asynchronous active-low reset
//     i_ps2_clk   PS/2 clock pin (asynchronous, idles high)
//     i_ps2_data  PS/2 data pin (asynchronous, idles high)
//     o_ready     1-cycle pulse, new byte valid on o_count
//     o_count     last good received byte, held between frames
//     o_error     1-cycle pulse, frame discarded
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ready,
  output logic [7:0] o_count,
  output logic       o_error
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic              ps2_clk_p0, ps2_clk_p1;
  logic              ps2_data_p0, ps2_data_p1;
  logic              ps2_clk_filt, ps2_clk_filt_d;
  logic [FCNT_W-1:0] filt_cnt;
  logic              vld_p2;
  logic              smp_bit_p2;
  logic [7:0]        shreg;
  state_t            state;
  logic [2:0]        bitcnt;
  logic [TO_W-1:0]   to_cnt;
  logic              frame_ok;

  // Stage p0/p1: two-flop synchronizers, then the ps2_clk glitch filter.
  // The filtered clock only moves after FILTER_LEN consecutive synced samples
  // disagree with it, so short spikes reset the counter and are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps2_clk_p0     <= 1'b1;
      ps2_clk_p1     <= 1'b1;
      ps2_data_p0    <= 1'b1;
      ps2_data_p1    <= 1'b1;
      ps2_clk_filt   <= 1'b1;
      ps2_clk_filt_d <= 1'b1;
      filt_cnt       <= '0;
      vld_p2         <= 1'b0;
    end else begin
      ps2_clk_p0     <= i_ps2_clk;
      ps2_clk_p1     <= ps2_clk_p0;
      ps2_data_p0    <= i_ps2_data;
      ps2_data_p1    <= ps2_data_p0;
      ps2_clk_filt_d <= ps2_clk_filt;
      if (ps2_clk_p1 != ps2_clk_filt) begin
        if (filt_cnt == FCNT_LAST) begin
          ps2_clk_filt <= ~ps2_clk_filt;
          filt_cnt     <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
      // Stage p2: sample strobe on the high->low edge of the filtered clock.
      vld_p2 <= ps2_clk_filt_d & ~ps2_clk_filt;
    end
  end

  // Data bit captured in the same cycle the strobe is generated.
  always_ff @(posedge i_clk) begin
    smp_bit_p2 <= ps2_data_p1;
  end

  // Stage p3: frame assembly; data bits shift in LSB first.
  always_ff @(posedge i_clk) begin
    if (vld_p2 && state == ST_DATA) begin
      shreg <= {smp_bit_p2, shreg[7:1]};
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge i_clk) begin
    if (vld_p2 && state == ST_PARITY) begin
      parity_q <= smp_bit_p2;
    end
  end

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign frame_ok = smp_bit_p2 & (^{shreg, parity_q});
`else
  assign frame_ok = smp_bit_p2;
`endif

  // A sample event has priority over the timeout: it clears the counter and the
  // frame carries on even if the counter was about to expire.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      bitcnt  <= '0;
      to_cnt  <= '0;
      o_ready <= 1'b0;
      o_error <= 1'b0;
      o_count <= 8'h00;
    end else begin
      o_ready <= 1'b0;
      o_error <= 1'b0;
      if (vld_p2) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!smp_bit_p2) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end else begin
              o_error <= 1'b1;
            end
          end
          ST_DATA: begin
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (frame_ok) begin
              o_count <= shreg;
              o_ready <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TO_LAST) begin
          state   <= ST_IDLE;
          to_cnt  <= '0;
          o_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: directed frames plus randomized frames, checked
// against a frame-level reference model (byte/parity/stop rules, pulse counts,
// pin-to-output latency of 2 + FILTER_LEN + 2 cycles).
module tb_ps2_keyboard_rx;

  localparam int FL  = 8;
  localparam int TO  = 400;
  localparam int H   = 30;
  localparam int LAT = FL + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready;
  logic       error;
  logic [7:0] count;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_ready   (ready),
    .o_count   (count),
    .o_error   (error)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  int         ready_seen = 0;
  int         error_seen = 0;
  int         last_ready_cyc = -1;
  int         last_err_cyc = -1;
  int         fall_cyc = 0;
  logic [7:0] exp_count = 8'h00;
  logic [7:0] prev_count = 8'h00;
  logic       prev_ready = 1'b0;
  logic       prev_error = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse exclusivity, pulse width, o_count only moves with o_ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready) begin
        ready_seen++;
        last_ready_cyc = cyc;
        check("ready_width", 32'(prev_ready), 0);
      end
      if (error) begin
        error_seen++;
        last_err_cyc = cyc;
        check("error_width", 32'(prev_error), 0);
      end
      if (ready || error) check("ready_error_exclusive", 32'(ready & error), 0);
      if (count !== prev_count) check("count_only_with_ready", 32'(ready), 1);
    end
    prev_ready = ready;
    prev_error = error;
    prev_count = count;
  end

  // Reference rule: a frame is accepted when stop is 1 and, with parity checking
  // enabled, data plus parity hold an odd number of ones.
  function automatic logic frame_good(input logic [7:0] b, input logic par, input logic stp);
`ifdef PS2_RX_PARITY_CHECK_EN
    return stp && (($countones({b, par}) % 2) == 1);
`else
    return stp;
`endif
  endfunction

  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H - 15) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                           input logic stp, input int gbit);
    int   r0;
    int   e0;
    logic good;
    r0 = ready_seen;
    e0 = error_seen;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], gbit == i);
    ps2_bit(par, 1'b0);
    ps2_bit(stp, 1'b0);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    good = frame_good(b, par, stp);
    if (good) exp_count = b;
    check({tag, "_ready_pulses"}, ready_seen - r0, good ? 1 : 0);
    check({tag, "_error_pulses"}, error_seen - e0, good ? 0 : 1);
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_latency"}, (good ? last_ready_cyc : last_err_cyc) - fall_cyc, LAT);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int         r0;
    int         e0;
    int         w;
    logic [7:0] b;
    logic       par;
    logic       stp;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 0);
    check("reset_error", 32'(error), 0);
    check("reset_count", 32'(count), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frames
    run_frame("t1_1C", 8'h1C, 1'b0, 1'b1, -1);
    run_frame("t2_F0", 8'hF0, 1'b1, 1'b1, -1);
    // Wrong parity: dropped only when parity checking is built in
    run_frame("t3_badpar", 8'h1C, 1'b1, 1'b1, -1);
    // Stop bit low, then the same byte sent correctly
    run_frame("t4_stop0", 8'h5A, 1'b1, 1'b0, -1);
    run_frame("t4_5A", 8'h5A, 1'b1, 1'b1, -1);

    // Clock stops after 4 data bits
    r0 = ready_seen;
    e0 = error_seen;
    b  = 8'($urandom);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
    w = 0;
    while (error_seen == e0 && w < TO + 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("t5_timeout_pulses", error_seen - e0, 1);
    check("t5_timeout_cycle", last_err_cyc - fall_cyc, TO + LAT);
    check("t5_timeout_no_ready", ready_seen - r0, 0);
    check("t5_timeout_count", 32'(count), 32'(exp_count));
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    run_frame("t5_29", 8'h29, 1'b0, 1'b1, -1);

    // Stray clock fall with data high while idle: start-bit error
    r0 = ready_seen;
    e0 = error_seen;
    ps2_bit(1'b1, 1'b0);
    repeat (H) @(negedge clk);
    check("start_err_pulses", error_seen - e0, 1);
    check("start_err_no_ready", ready_seen - r0, 0);
    check("start_err_latency", last_err_cyc - fall_cyc, LAT);

    // Short low glitch on ps2_clk in the middle of a frame
    run_frame("t6_glitch", 8'hB3, 1'b0, 1'b1, 3);

    // Reset in the middle of a frame
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(ready), 0);
    check("t6_rst_error", 32'(error), 0);
    check("t6_rst_count", 32'(count), 0);
    exp_count = 8'h00;
    ps2_data  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_frame("t6_after_reset", 8'hA5, 1'b1, 1'b1, -1);

    // Randomized frames, occasionally with bad parity or a bad stop bit
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      par = ~^b;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", k), b, par, stp, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
